// File: rtl/lane_arb_pkg.sv
// Shared types and width helpers for the lane request arbiter.
// The request struct is sized for the widest supported configuration; narrower lanes are zero-extended into it.
package lane_arb_pkg;

    localparam int ARB_ADDR_W = 64;
    localparam int ARB_SIZE_W = 3;
    localparam int ARB_SRC_W  = 8;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] address;
        logic [ARB_ADDR_W-1:0] data;
        logic                  is_store;
        logic [ARB_SIZE_W-1:0] size;
        logic [ARB_SRC_W-1:0]  source;
    } arb_req_t;

    function automatic int src_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer, wrapping N-1 -> 0.
// The pointer moves past the winner only when adv_i reports the grant was taken.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          vld_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;

    // Priority k is held by the lane sitting k positions after the pointer.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int l = 0; l < N; l++) begin
                if (!found && req_i[l] &&
                    ((int'(ptr_q) + k == l) || (int'(ptr_q) + k == l + N))) begin
                    found      = 1'b1;
                    grant_o[l] = 1'b1;
                    idx_o      = PW'(l);
                end
            end
        end
        vld_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && found) begin
            ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lane_req_arbiter.sv
// Merges per-lane request channels onto one memory port (1-cycle register, full throughput) and routes responses back by source ID.
// a_ready is withheld while the output register is stalled or a lane hits its outstanding limit; responses pass through combinationally.
module lane_req_arbiter
    import lane_arb_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int LOGSIZE_WIDTH   = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SOURCE_WIDTH    = src_width(NUM_LANES)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_LANES-1:0]               a_valid,
    output logic [NUM_LANES-1:0]               a_ready,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
    input  logic [NUM_LANES-1:0]               a_is_store,
    input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
    output logic [NUM_LANES-1:0]               d_valid,
    input  logic [NUM_LANES-1:0]               d_ready,
    output logic [DATA_WIDTH*NUM_LANES-1:0]    d_data,
    output logic [NUM_LANES-1:0]               d_is_store,
    output logic                               mem_a_valid,
    input  logic                               mem_a_ready,
    output logic [DATA_WIDTH-1:0]              mem_a_address,
    output logic [DATA_WIDTH-1:0]              mem_a_data,
    output logic                               mem_a_is_store,
    output logic [LOGSIZE_WIDTH-1:0]           mem_a_size,
    output logic [SOURCE_WIDTH-1:0]            mem_a_source,
    input  logic                               mem_d_valid,
    output logic                               mem_d_ready,
    input  logic [SOURCE_WIDTH-1:0]            mem_d_source,
    input  logic [DATA_WIDTH-1:0]              mem_d_data,
    input  logic                               mem_d_is_store,
    output logic                               idle,
    output logic                               err
);

    localparam int CW = cnt_width(MAX_OUTSTANDING);
    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    arb_req_t             req_q, req_d;
    logic                 mem_a_valid_q, mem_a_valid_d;
    logic [CW-1:0]        outst_q [NUM_LANES];
    logic [CW-1:0]        outst_d [NUM_LANES];
    logic                 err_q, err_d;
    logic [NUM_LANES-1:0] eligible, grant, a_fire, d_fire;
    logic [PW-1:0]        win_idx;
    logic                 win_vld, can_load, fire_any, src_ok;

    always_comb begin
        eligible = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            eligible[l] = a_valid[l] && (outst_q[l] < CW'(MAX_OUTSTANDING));
        end
    end

    // Reset gating keeps a_ready low while the async reset is held.
    assign can_load = reset && (!mem_a_valid_q || mem_a_ready);
    assign a_ready  = grant & {NUM_LANES{can_load}};
    assign a_fire   = a_ready & a_valid;
    assign fire_any = win_vld && can_load;

    rr_arbiter #(.N(NUM_LANES)) u_rr (
        .clk     (clock),
        .rst_n   (reset),
        .req_i   (eligible),
        .adv_i   (fire_any),
        .grant_o (grant),
        .idx_o   (win_idx),
        .vld_o   (win_vld)
    );

    always_comb begin
        req_d         = req_q;
        mem_a_valid_d = mem_a_valid_q;
        if (can_load) begin
            mem_a_valid_d = fire_any;
        end
        if (fire_any) begin
            req_d.source = ARB_SRC_W'(win_idx);
            for (int l = 0; l < NUM_LANES; l++) begin
                if (grant[l]) begin
                    req_d.address  = ARB_ADDR_W'(a_address[DATA_WIDTH*l +: DATA_WIDTH]);
                    req_d.data     = ARB_ADDR_W'(a_data[DATA_WIDTH*l +: DATA_WIDTH]);
                    req_d.is_store = a_is_store[l];
                    req_d.size     = ARB_SIZE_W'(a_size[LOGSIZE_WIDTH*l +: LOGSIZE_WIDTH]);
                end
            end
        end
    end

    assign mem_a_valid    = mem_a_valid_q;
    assign mem_a_address  = DATA_WIDTH'(req_q.address);
    assign mem_a_data     = DATA_WIDTH'(req_q.data);
    assign mem_a_is_store = req_q.is_store;
    assign mem_a_size     = LOGSIZE_WIDTH'(req_q.size);
    assign mem_a_source   = SOURCE_WIDTH'(req_q.source);

    // Out-of-range sources are swallowed so a bad response cannot wedge the memory side.
    always_comb begin
        src_ok      = int'(mem_d_source) < NUM_LANES;
        d_valid     = '0;
        mem_d_ready = reset && !src_ok;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (mem_d_source == SOURCE_WIDTH'(l)) begin
                d_valid[l]  = reset && mem_d_valid;
                mem_d_ready = reset && d_ready[l];
            end
        end
    end

    assign d_fire     = d_valid & d_ready;
    assign d_data     = {NUM_LANES{mem_d_data}};
    assign d_is_store = {NUM_LANES{mem_d_is_store}};

    always_comb begin
        outst_d = outst_q;
        err_d   = err_q;
        if (mem_d_valid && !src_ok) begin
            err_d = 1'b1;
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (d_fire[l] && outst_q[l] == '0) begin
                err_d = 1'b1;
            end
            if (a_fire[l] && !d_fire[l]) begin
                outst_d[l] = outst_q[l] + CW'(1);
            end else if (!a_fire[l] && d_fire[l] && outst_q[l] != '0) begin
                outst_d[l] = outst_q[l] - CW'(1);
            end
        end
    end

    always_comb begin
        idle = !mem_a_valid_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (outst_q[l] != '0) begin
                idle = 1'b0;
            end
        end
    end

    assign err = err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_a_valid_q <= 1'b0;
            req_q         <= '0;
            err_q         <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                outst_q[l] <= '0;
            end
        end else begin
            mem_a_valid_q <= mem_a_valid_d;
            req_q         <= req_d;
            err_q         <= err_d;
            outst_q       <= outst_d;
        end
    end

endmodule

// File: tb/tb_lane_req_arbiter.sv
// Directed scenarios plus a randomized run against a lane-level reference model of the arbiter.
module tb_lane_req_arbiter;

    localparam int NL = 4;
    localparam int DW = 64;
    localparam int SW = 3;
    localparam int MO = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [NL-1:0]   a_valid, a_ready, a_is_store, d_valid, d_ready, d_is_store;
    logic [DW*NL-1:0] a_address, a_data, d_data;
    logic [3*NL-1:0] a_size;
    logic            mem_a_valid, mem_a_ready, mem_a_is_store;
    logic [DW-1:0]   mem_a_address, mem_a_data, mem_d_data;
    logic [2:0]      mem_a_size;
    logic [SW-1:0]   mem_a_source, mem_d_source;
    logic            mem_d_valid, mem_d_ready, mem_d_is_store, idle, err;

    int vec  = 0;
    int errs = 0;

    // reference model state
    int          m_out [NL];
    int          m_pend[NL];
    int          m_ptr;
    logic        m_valid;
    logic [63:0] m_addr, m_data;
    logic [2:0]  m_size;
    logic        m_store;
    int          m_src;

    lane_req_arbiter #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(3),
        .MAX_OUTSTANDING(MO), .SOURCE_WIDTH(SW)
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_address(a_address),
        .a_is_store(a_is_store), .a_size(a_size), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_is_store(d_is_store),
        .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready),
        .mem_a_address(mem_a_address), .mem_a_data(mem_a_data),
        .mem_a_is_store(mem_a_is_store), .mem_a_size(mem_a_size), .mem_a_source(mem_a_source),
        .mem_d_valid(mem_d_valid), .mem_d_ready(mem_d_ready), .mem_d_source(mem_d_source),
        .mem_d_data(mem_d_data), .mem_d_is_store(mem_d_is_store),
        .idle(idle), .err(err)
    );

    always #5 clock = ~clock;

    task automatic clear_inputs();
        a_valid = '0; a_address = '0; a_is_store = '0; a_size = '0; a_data = '0;
        d_ready = '0; mem_a_ready = 1'b0; mem_d_valid = 1'b0; mem_d_source = '0;
        mem_d_data = '0; mem_d_is_store = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_lane(input int l, input logic [63:0] addr, input logic st,
                            input logic [2:0] sz, input logic [63:0] dat);
        a_address[l*DW +: DW] = addr;
        a_data[l*DW +: DW]    = dat;
        a_is_store[l]         = st;
        a_size[l*3 +: 3]      = sz;
    endtask

    function automatic int pick(input logic [NL-1:0] v);
        for (int k = 0; k < NL; k++) begin
            int l;
            l = (m_ptr + k) % NL;
            if (v[l] && m_out[l] < MO) return l;
        end
        return -1;
    endfunction

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        a_valid = 4'hf;
        mem_d_valid = 1'b1;
        #2;
        vec++; if (mem_a_valid !== 1'b0) begin errs++; $display("FAIL reset_mem_a_valid got=%b exp=0", mem_a_valid); end
        vec++; if (a_ready !== 4'h0) begin errs++; $display("FAIL reset_a_ready got=%b exp=0000", a_ready); end
        vec++; if (d_valid !== 4'h0) begin errs++; $display("FAIL reset_d_valid got=%b exp=0000", d_valid); end
        vec++; if (idle !== 1'b1) begin errs++; $display("FAIL reset_idle got=%b exp=1", idle); end
        vec++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", err); end
        do_reset();
    endtask

    task automatic test_single_lane();
        do_reset();
        set_lane(0, 64'h1000, 1'b0, 3'd3, 64'h0);
        a_valid = 4'b0001; mem_a_ready = 1'b1;
        #2;
        vec++; if (a_ready !== 4'b0001) begin errs++; $display("FAIL single_a_ready got=%b exp=0001", a_ready); end
        next_cycle();
        a_valid = '0;
        vec++; if (mem_a_valid !== 1'b1) begin errs++; $display("FAIL single_mem_a_valid got=%b exp=1", mem_a_valid); end
        vec++; if (mem_a_source !== 3'd0) begin errs++; $display("FAIL single_source got=%0d exp=0", mem_a_source); end
        vec++; if (mem_a_address !== 64'h1000) begin errs++; $display("FAIL single_addr got=%h exp=1000", mem_a_address); end
        vec++; if (mem_a_size !== 3'd3) begin errs++; $display("FAIL single_size got=%0d exp=3", mem_a_size); end
        vec++; if (idle !== 1'b0) begin errs++; $display("FAIL single_busy got=%b exp=0", idle); end
        next_cycle();
        vec++; if (mem_a_valid !== 1'b0) begin errs++; $display("FAIL single_drained got=%b exp=0", mem_a_valid); end
        mem_d_valid = 1'b1; mem_d_source = 3'd0; mem_d_data = 64'hdead_beef_0123_4567; d_ready = 4'b0001;
        #2;
        vec++; if (d_valid !== 4'b0001) begin errs++; $display("FAIL single_d_valid got=%b exp=0001", d_valid); end
        vec++; if (mem_d_ready !== 1'b1) begin errs++; $display("FAIL single_mem_d_ready got=%b exp=1", mem_d_ready); end
        vec++; if (d_data[3*DW +: DW] !== 64'hdead_beef_0123_4567) begin errs++; $display("FAIL single_d_data got=%h exp=deadbeef01234567", d_data[3*DW +: DW]); end
        next_cycle();
        mem_d_valid = 1'b0; d_ready = '0;
        #2;
        vec++; if (idle !== 1'b1) begin errs++; $display("FAIL single_idle_back got=%b exp=1", idle); end
    endtask

    task automatic test_round_robin();
        int exp_src [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int l = 0; l < NL; l++) set_lane(l, 64'h100 * (l + 1), 1'b0, 3'd2, 64'h0);
        a_valid = 4'hf; mem_a_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #2;
            vec++; if (a_ready !== (4'b0001 << exp_src[k])) begin errs++; $display("FAIL rr_a_ready[%0d] got=%b exp_lane=%0d", k, a_ready, exp_src[k]); end
            next_cycle();
            vec++; if (mem_a_valid !== 1'b1 || mem_a_source !== 3'(exp_src[k])) begin errs++; $display("FAIL rr_source[%0d] got v=%b src=%0d exp v=1 src=%0d", k, mem_a_valid, mem_a_source, exp_src[k]); end
        end
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        set_lane(2, 64'h2200, 1'b1, 3'd1, 64'h55);
        a_valid = 4'b0100; mem_a_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            vec++; if (a_ready !== 4'b0100) begin errs++; $display("FAIL limit_accept[%0d] got=%b exp=0100", k, a_ready); end
            next_cycle();
        end
        mem_d_valid = 1'b1; mem_d_source = 3'd2; mem_d_is_store = 1'b1; d_ready = 4'b0100;
        #2;
        vec++; if (a_ready !== 4'b0000) begin errs++; $display("FAIL limit_block got=%b exp=0000", a_ready); end
        vec++; if (d_is_store[2] !== 1'b1) begin errs++; $display("FAIL limit_d_is_store got=%b exp=1", d_is_store[2]); end
        next_cycle();
        mem_d_valid = 1'b0; d_ready = '0;
        #2;
        vec++; if (a_ready !== 4'b0100) begin errs++; $display("FAIL limit_release got=%b exp=0100", a_ready); end
        vec++; if (err !== 1'b0) begin errs++; $display("FAIL limit_err got=%b exp=0", err); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_lane(0, 64'h2040, 1'b0, 3'd3, 64'h0);
        a_valid = 4'b0001; mem_a_ready = 1'b0;
        #2;
        vec++; if (a_ready !== 4'b0001) begin errs++; $display("FAIL bp_first got=%b exp=0001", a_ready); end
        next_cycle();
        for (int l = 0; l < NL; l++) set_lane(l, 64'h3000 + l, 1'b1, 3'd0, 64'h77);
        a_valid = 4'hf;
        for (int k = 0; k < 3; k++) begin
            #2;
            vec++; if (mem_a_valid !== 1'b1 || mem_a_address !== 64'h2040 || mem_a_source !== 3'd0 || mem_a_is_store !== 1'b0)
                begin errs++; $display("FAIL bp_hold[%0d] got v=%b a=%h s=%0d st=%b exp v=1 a=2040 s=0 st=0", k, mem_a_valid, mem_a_address, mem_a_source, mem_a_is_store); end
            vec++; if (a_ready !== 4'h0) begin errs++; $display("FAIL bp_a_ready[%0d] got=%b exp=0000", k, a_ready); end
            next_cycle();
        end
        mem_a_ready = 1'b1;
        #2;
        vec++; if (a_ready !== 4'b0010) begin errs++; $display("FAIL bp_release got=%b exp=0010", a_ready); end
        next_cycle();
        vec++; if (mem_a_source !== 3'd1 || mem_a_address !== 64'h3001) begin errs++; $display("FAIL bp_next got s=%0d a=%h exp s=1 a=3001", mem_a_source, mem_a_address); end
    endtask

    task automatic test_bad_source();
        do_reset();
        mem_d_valid = 1'b1; mem_d_source = 3'd3; d_ready = 4'b1000;
        #2;
        vec++; if (d_valid !== 4'b1000) begin errs++; $display("FAIL zero_out_d_valid got=%b exp=1000", d_valid); end
        next_cycle();
        mem_d_valid = 1'b0; d_ready = '0;
        #2;
        vec++; if (err !== 1'b1 || idle !== 1'b1) begin errs++; $display("FAIL zero_out_err got err=%b idle=%b exp err=1 idle=1", err, idle); end
        do_reset();
        mem_d_valid = 1'b1; mem_d_source = 3'd5; d_ready = 4'b0000;
        #2;
        vec++; if (mem_d_ready !== 1'b1) begin errs++; $display("FAIL badsrc_ready got=%b exp=1", mem_d_ready); end
        vec++; if (d_valid !== 4'h0) begin errs++; $display("FAIL badsrc_d_valid got=%b exp=0000", d_valid); end
        next_cycle();
        mem_d_valid = 1'b0;
        vec++; if (err !== 1'b1) begin errs++; $display("FAIL badsrc_err got=%b exp=1", err); end
        repeat (3) next_cycle();
        vec++; if (err !== 1'b1) begin errs++; $display("FAIL badsrc_sticky got=%b exp=1", err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_lane(1, 64'h1110, 1'b0, 3'd2, 64'h0);
        a_valid = 4'b0010; mem_a_ready = 1'b1;
        repeat (3) next_cycle();
        a_valid = 4'hf;
        vec++; if (idle !== 1'b0 || mem_a_valid !== 1'b1) begin errs++; $display("FAIL areset_busy got idle=%b v=%b exp idle=0 v=1", idle, mem_a_valid); end
        #2;
        reset = 1'b0;
        #1;
        vec++; if (mem_a_valid !== 1'b0 || idle !== 1'b1 || a_ready !== 4'h0)
            begin errs++; $display("FAIL areset_now got v=%b idle=%b ar=%b exp v=0 idle=1 ar=0000", mem_a_valid, idle, a_ready); end
        next_cycle();
        reset = 1'b1;
        #2;
        vec++; if (a_ready !== 4'b0001) begin errs++; $display("FAIL areset_first_grant got=%b exp=0001", a_ready); end
    endtask

    task automatic test_random();
        int w, src, cands[$];
        logic can_load;
        logic [NL-1:0] exp_ar, exp_dv;
        logic exp_idle;
        do_reset();
        for (int l = 0; l < NL; l++) begin m_out[l] = 0; m_pend[l] = 0; end
        m_ptr = 0; m_valid = 1'b0; m_addr = '0; m_data = '0; m_size = '0; m_store = 1'b0; m_src = 0;
        for (int c = 0; c < 400; c++) begin
            a_valid = NL'($urandom);
            for (int l = 0; l < NL; l++)
                set_lane(l, {$urandom, $urandom}, 1'($urandom), 3'($urandom), {$urandom, $urandom});
            mem_a_ready = ($urandom_range(0, 3) != 0);
            d_ready = NL'($urandom);
            cands.delete();
            for (int l = 0; l < NL; l++) if (m_pend[l] > 0) cands.push_back(l);
            mem_d_valid = 1'b0; mem_d_source = '0; src = 0;
            if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
                src = cands[$urandom_range(0, cands.size() - 1)];
                mem_d_valid = 1'b1; mem_d_source = SW'(src);
            end
            mem_d_data = {$urandom, $urandom};
            #2;
            can_load = !m_valid || mem_a_ready;
            w = pick(a_valid);
            exp_ar = (w >= 0 && can_load) ? (NL'(1) << w) : '0;
            exp_dv = mem_d_valid ? (NL'(1) << src) : '0;
            exp_idle = !m_valid;
            for (int l = 0; l < NL; l++) if (m_out[l] != 0) exp_idle = 1'b0;
            vec++; if (a_ready !== exp_ar) begin errs++; $display("FAIL rnd_a_ready[%0d] got=%b exp=%b", c, a_ready, exp_ar); end
            vec++; if (mem_a_valid !== m_valid) begin errs++; $display("FAIL rnd_mem_a_valid[%0d] got=%b exp=%b", c, mem_a_valid, m_valid); end
            if (m_valid) begin
                vec++; if (mem_a_address !== m_addr || mem_a_data !== m_data || mem_a_source !== SW'(m_src) ||
                           mem_a_size !== m_size || mem_a_is_store !== m_store)
                    begin errs++; $display("FAIL rnd_req[%0d] got a=%h d=%h s=%0d exp a=%h d=%h s=%0d", c, mem_a_address, mem_a_data, mem_a_source, m_addr, m_data, m_src); end
            end
            vec++; if (d_valid !== exp_dv) begin errs++; $display("FAIL rnd_d_valid[%0d] got=%b exp=%b", c, d_valid, exp_dv); end
            vec++; if (mem_d_ready !== d_ready[src]) begin errs++; $display("FAIL rnd_mem_d_ready[%0d] got=%b exp=%b", c, mem_d_ready, d_ready[src]); end
            vec++; if (idle !== exp_idle || err !== 1'b0) begin errs++; $display("FAIL rnd_idle_err[%0d] got idle=%b err=%b exp idle=%b err=0", c, idle, err, exp_idle); end
            if (m_valid && mem_a_ready) m_pend[m_src]++;
            if (can_load) begin
                if (w >= 0) begin
                    m_valid = 1'b1; m_src = w;
                    m_addr  = a_address[w*DW +: DW];
                    m_data  = a_data[w*DW +: DW];
                    m_size  = a_size[w*3 +: 3];
                    m_store = a_is_store[w];
                    m_out[w]++;
                    m_ptr = (w + 1) % NL;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (mem_d_valid && d_ready[src]) begin
                m_out[src]--; m_pend[src]--;
            end
            next_cycle();
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        test_reset();
        test_single_lane();
        test_round_robin();
        test_outstanding_limit();
        test_backpressure();
        test_bad_source();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
